// File: rtl/fetch_buffer_pkg.sv
// fetch_buffer_pkg: packet width and field layout shared by fetch, fetch_buffer and decode
package fetch_buffer_pkg;
  localparam int FB_PKT_WIDTH = 103;
  typedef struct packed {
    logic [6:0]  exception;
    logic [31:0] pc_next;
    logic [31:0] pc;
    logic [31:0] inst;
  } fb_pkt_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-in/2-out circular packet FIFO between instruction fetch and the decoder lanes
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [1:0]                  in_valid,
  input  logic [2*FB_PKT_WIDTH-1:0]   in_data,
  output logic                        in_ready,
  output logic [1:0]                  out_valid,
  output logic [2*FB_PKT_WIDTH-1:0]   out_data,
  input  logic [1:0]                  out_accept,
  output logic [$clog2(DEPTH):0]      count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [FB_PKT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic push0, push1;
  logic [1:0] n_push, n_pop;
  logic [CW-1:0] count_next;
  assign in_ready = count <= CW'(DEPTH - 2);
  assign out_valid = {count >= CW'(2), count != '0};
  assign push0 = in_ready && !flush && !rst && in_valid[0];
  assign push1 = push0 && in_valid[1];
  assign n_push = {1'b0, push0} + {1'b0, push1};
  assign n_pop = flush ? 2'd0 : {1'b0, out_accept[0] & out_valid[0]} + {1'b0, &out_accept & out_valid[1]};
  assign count_next = count + CW'(n_push) - CW'(n_pop);
  assign out_data = {mem[head + AW'(1)], mem[head]};
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(n_pop);
      tail  <= tail + AW'(n_push);
      count <= count_next;
    end
  end
  always_ff @(posedge clk) begin
    if (push0) mem[tail] <= in_data[FB_PKT_WIDTH-1:0];
    if (push1) mem[tail + AW'(1)] <= in_data[2*FB_PKT_WIDTH-1:FB_PKT_WIDTH];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_lane_order: assert (in_valid != 2'b10);
      a_count_range: assert (flush || count_next <= CW'(DEPTH));
    end
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: queue-model checking of fetch_buffer with directed and random traffic
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;
  localparam int DEPTH = 8;
  logic clk = 0;
  logic rst = 1;
  logic flush = 0;
  logic [1:0] in_valid = 0;
  logic [2*FB_PKT_WIDTH-1:0] in_data = '0;
  logic in_ready;
  logic [1:0] out_valid;
  logic [2*FB_PKT_WIDTH-1:0] out_data;
  logic [1:0] out_accept = 0;
  logic [$clog2(DEPTH):0] count;
  int checks = 0;
  int errors = 0;
  bit started = 0;
  logic [31:0] pc = 32'h1c000000;
  logic [31:0] last_pc;
  logic [FB_PKT_WIDTH-1:0] q[$];
  int mpop;
  bit mpush0, mpush1;

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_accept(out_accept), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [FB_PKT_WIDTH-1:0] mk(input logic [31:0] p);
    fb_pkt_t k;
    k.exception = 7'($urandom);
    k.pc_next = p + 32'd4;
    k.pc = p;
    k.inst = $urandom;
    return k;
  endfunction

  function automatic logic [31:0] pc_of(input logic [FB_PKT_WIDTH-1:0] x);
    fb_pkt_t k;
    k = x;
    return k.pc;
  endfunction

  task automatic step(input logic [1:0] v, input logic [1:0] a, input logic f, input logic r);
    in_valid = v;
    in_data = {mk(pc + 32'd4), mk(pc)};
    last_pc = pc;
    out_accept = a;
    flush = f;
    rst = r;
    @(posedge clk);
    #1;
    pc = pc + 32'd8;
  endtask

  always @(posedge clk) begin
    if (rst || flush) q.delete();
    else begin
      mpush0 = (DEPTH - q.size() >= 2) && in_valid[0];
      mpush1 = mpush0 && in_valid[1];
      mpop = 0;
      if (out_accept[0] && q.size() >= 1) mpop = 1;
      if (out_accept == 2'b11 && q.size() >= 2) mpop = 2;
      repeat (mpop) void'(q.pop_front());
      if (mpush0) q.push_back(in_data[FB_PKT_WIDTH-1:0]);
      if (mpush1) q.push_back(in_data[2*FB_PKT_WIDTH-1:FB_PKT_WIDTH]);
    end
    if (rst) started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_count", 128'(count), 128'(q.size()));
      chk("model_in_ready", 128'(in_ready), 128'(DEPTH - q.size() >= 2));
      chk("model_out_valid", 128'(out_valid), 128'({q.size() >= 2, q.size() >= 1}));
      if (q.size() >= 1) chk("model_lane0", 128'(out_data[FB_PKT_WIDTH-1:0]), 128'(q[0]));
      if (q.size() >= 2) chk("model_lane1", 128'(out_data[2*FB_PKT_WIDTH-1:FB_PKT_WIDTH]), 128'(q[1]));
    end
  end

  initial begin
    int r;
    logic [1:0] v, a;
    step(2'b00, 2'b00, 0, 1);
    chk("rst_count", 128'(count), 0);
    chk("rst_in_ready", 128'(in_ready), 1);
    chk("rst_out_valid", 128'(out_valid), 0);
    pc = 32'h1c000000;
    step(2'b11, 2'b00, 0, 0);
    chk("t1_out_valid", 128'(out_valid), 3);
    chk("t1_count", 128'(count), 2);
    chk("t1_pc0", 128'(pc_of(out_data[FB_PKT_WIDTH-1:0])), 128'h1c000000);
    chk("t1_pc1", 128'(pc_of(out_data[2*FB_PKT_WIDTH-1:FB_PKT_WIDTH])), 128'h1c000004);
    step(2'b00, 2'b00, 0, 1);
    repeat (4) step(2'b11, 2'b00, 0, 0);
    chk("t2_full_count", 128'(count), 8);
    chk("t2_full_ready", 128'(in_ready), 0);
    step(2'b11, 2'b00, 0, 0);
    chk("t2_ignored_push", 128'(count), 8);
    step(2'b00, 2'b01, 0, 0);
    chk("t2_pop1_count", 128'(count), 7);
    chk("t2_pop1_ready", 128'(in_ready), 0);
    step(2'b00, 2'b11, 0, 0);
    chk("t2_pop2_count", 128'(count), 5);
    chk("t2_pop2_ready", 128'(in_ready), 1);
    step(2'b01, 2'b00, 0, 0);
    repeat (20) step(2'b11, 2'b11, 0, 0);
    chk("t3_steady_count", 128'(count), 6);
    chk("t3_seq_pc", 128'(pc_of(out_data[2*FB_PKT_WIDTH-1:FB_PKT_WIDTH]) - pc_of(out_data[FB_PKT_WIDTH-1:0])), 4);
    step(2'b00, 2'b01, 0, 0);
    chk("t4_pre_count", 128'(count), 5);
    step(2'b11, 2'b11, 1, 0);
    chk("t4_flush_count", 128'(count), 0);
    chk("t4_flush_valid", 128'(out_valid), 0);
    chk("t4_flush_ready", 128'(in_ready), 1);
    step(2'b00, 2'b00, 0, 0);
    chk("t4_after_flush", 128'(count), 0);
    step(2'b01, 2'b00, 0, 0);
    step(2'b01, 2'b11, 0, 0);
    chk("t5_count", 128'(count), 1);
    chk("t5_new_pc", 128'(pc_of(out_data[FB_PKT_WIDTH-1:0])), 128'(last_pc));
    step(2'b11, 2'b00, 0, 0);
    step(2'b01, 2'b00, 0, 0);
    chk("t6_pre_count", 128'(count), 4);
    step(2'b00, 2'b00, 0, 1);
    chk("t6_rst_count", 128'(count), 0);
    chk("t6_rst_valid", 128'(out_valid), 0);
    chk("t6_rst_ready", 128'(in_ready), 1);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 2);
      v = (r == 2) ? 2'b11 : 2'(r);
      r = $urandom_range(0, 2);
      a = (r == 2) ? 2'b11 : 2'(r);
      step(v, a, $urandom_range(0, 40) == 0, $urandom_range(0, 200) == 0);
    end
    step(2'b00, 2'b00, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
